// File: rtl/qos_ctrl_fsm.sv
// qos_ctrl_fsm: QoS control FSM for a bank of NUM_CH FIFOs.
// Sequences RESET -> INIT -> IDLE <-> ACTIVE (and ERROR), latches the
// low/high flow-control thresholds while in INIT, and adds an idle
// hysteresis timer before ACTIVE falls back to IDLE.
// Optional feature macro: QOS_FSM_ERROR_EN -- when defined, a FIFO overflow
// seen in IDLE/ACTIVE sends the FSM to a sticky ERROR state; when undefined,
// overflows are ignored and ERROR is unreachable.
// State is exposed on state_out for observation (RESET=0 INIT=1 IDLE=2
// ACTIVE=3 ERROR=4).
module qos_ctrl_fsm #(
  parameter int NUM_CH   = 10,
  parameter int UMBRAL_W = 4,
  parameter int IDLE_DLY = 2
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [NUM_CH-1:0]   empties,
  input  logic [NUM_CH-1:0]   overflows,
  input  logic [UMBRAL_W-1:0] umbral_L_in,
  input  logic [UMBRAL_W-1:0] umbral_H_in,
  output logic                idle_out,
  output logic                active_out,
  output logic                error_out,
  output logic                cfg_err,
  output logic [2:0]          state_out,
  output logic [UMBRAL_W-1:0] umbral_L_out,
  output logic [UMBRAL_W-1:0] umbral_H_out
);

  localparam int CNT_W = $clog2(IDLE_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_DLY - 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_cnt_nxt;
  logic             all_empty;
  logic             thr_bad;
  logic             ovf_hit;

  assign all_empty = &empties;
  assign thr_bad   = (umbral_L_in > umbral_H_in);
  assign state_out = state;

`ifdef QOS_FSM_ERROR_EN
  assign ovf_hit = |overflows;
`else
  // Overflows have no effect in this build; fold them into a sink signal.
  logic unused_ovf;
  assign unused_ovf = ^overflows;
  assign ovf_hit    = 1'b0;
`endif

  // Next-state and idle-hysteresis counter logic; init overrides everything.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = '0;
    if (init) begin
      state_nxt = ST_INIT;
    end else begin
      case (state)
        ST_RESET:  state_nxt = ST_INIT;
        ST_INIT:   state_nxt = thr_bad ? ST_INIT : ST_IDLE;
        ST_IDLE: begin
          if (ovf_hit)         state_nxt = ST_ERROR;
          else if (!all_empty) state_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (ovf_hit) begin
            state_nxt = ST_ERROR;
          end else if (all_empty) begin
            if (idle_cnt >= CNT_LAST) state_nxt = ST_IDLE;
            else                      idle_cnt_nxt = idle_cnt + CNT_W'(1);
          end
        end
`ifdef QOS_FSM_ERROR_EN
        ST_ERROR:  state_nxt = ST_ERROR;
`else
        ST_ERROR:  state_nxt = ST_INIT;
`endif
        default:   state_nxt = ST_INIT;
      endcase
    end
  end

  // State, counter, registered Moore flags and threshold shadows.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= ST_RESET;
      idle_cnt     <= '0;
      idle_out     <= 1'b0;
      active_out   <= 1'b0;
      error_out    <= 1'b0;
      cfg_err      <= 1'b0;
      umbral_L_out <= '0;
      umbral_H_out <= '0;
    end else begin
      state      <= state_nxt;
      idle_cnt   <= idle_cnt_nxt;
      idle_out   <= (state_nxt == ST_IDLE);
      active_out <= (state_nxt == ST_ACTIVE);
`ifdef QOS_FSM_ERROR_EN
      error_out  <= (state_nxt == ST_ERROR);
`else
      error_out  <= 1'b0;
`endif
      cfg_err    <= (state_nxt == ST_INIT) && thr_bad;
      // Shadows track the config inputs only while sitting in INIT.
      if (state == ST_INIT) begin
        umbral_L_out <= umbral_L_in;
        umbral_H_out <= umbral_H_in;
      end
    end
  end

endmodule
